// File: rtl/seq_marker_tx.sv
// ============================================================================
// Module      : seq_marker_tx
// Description : Serial frame transmitter. It sends a "101" sync marker and
//               then a parallel word MSB first, one bit per clock.
//               Define SEQ_MARKER_TX_GUARD_EN to add a trailing guard 0 bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_marker_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MK1   = 3'd1,
    MK0   = 3'd2,
    MK2   = 3'd3,
    DATA  = 3'd4
`ifdef SEQ_MARKER_TX_GUARD_EN
    , GUARD = 3'd5
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               x_q, x_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               accept;
`ifndef SEQ_MARKER_TX_GUARD_EN
  logic               last_d;
`endif

  // Outputs are decoded from the next state and registered, so x stays a
  // pure Moore output and ready_q always reflects the current slot.
  always_comb begin
    accept  = din_valid && ready_q;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MK1;
          sh_d    = din;
          cnt_d   = CNT_LAST;
        end
      end
      MK1: state_d = MK0;
      MK0: state_d = MK2;
      MK2: state_d = DATA;
      DATA: begin
        if (cnt_q != '0) begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
`ifdef SEQ_MARKER_TX_GUARD_EN
          state_d = GUARD;
`else
          state_d = accept ? MK1 : IDLE;
          if (accept) begin
            sh_d  = din;
            cnt_d = CNT_LAST;
          end
`endif
        end
      end
`ifdef SEQ_MARKER_TX_GUARD_EN
      GUARD: begin
        state_d = accept ? MK1 : IDLE;
        if (accept) begin
          sh_d  = din;
          cnt_d = CNT_LAST;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    case (state_d)
      MK1, MK2: x_d = 1'b1;
      DATA:     x_d = sh_d[DATA_W-1];
      default:  x_d = 1'b0;
    endcase

    busy_d = (state_d != IDLE);
`ifdef SEQ_MARKER_TX_GUARD_EN
    ready_d = (state_d == IDLE) || (state_d == GUARD);
    done_d  = (state_d == GUARD);
`else
    last_d  = (state_d == DATA) && (cnt_d == '0);
    ready_d = (state_d == IDLE) || last_d;
    done_d  = last_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign din_ready  = ready_q;
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_marker_tx.sv
// ============================================================================
// Module      : tb_seq_marker_tx
// Description : Self-checking bench for seq_marker_tx (DATA_W = 8 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_marker_tx;

`ifdef SEQ_MARKER_TX_GUARD_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int FL = 11 + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, busy, frame_done;
  logic [0:0] din1;
  logic       valid1;
  logic       ready1, x1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  logic mq[$];
  logic s_x, s_r, s_b, s_d;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ex, er, eb, ed;
  } vec_t;
  vec_t tbl[$];

  seq_marker_tx #(.DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .busy(busy), .frame_done(frame_done)
  );

  seq_marker_tx #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(valid1),
    .din_ready(ready1), .x(x1), .busy(busy1), .frame_done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    mq.push_back(1'b1);
    mq.push_back(1'b0);
    mq.push_back(1'b1);
    for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
    if (G != 0) mq.push_back(1'b0);
  endtask

  // One clock slot: drive, check the model at negedge, advance the model at the edge.
  task automatic step(input logic v, input logic [7:0] d);
    logic mx, mr;
    din_valid = v;
    din       = d;
    @(negedge clk);
    mx = (mq.size() != 0) ? mq[0] : 1'b0;
    mr = (mq.size() <= 1);
    chk("x", 32'(x), 32'(mx));
    chk("din_ready", 32'(din_ready), 32'(mr));
    chk("busy", 32'(busy), 32'(mq.size() != 0));
    chk("frame_done", 32'(frame_done), 32'(mq.size() == 1));
    s_x = x; s_r = din_ready; s_b = busy; s_d = frame_done;
    @(posedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
    if (v && mr) push_frame(d);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] d,
                     input logic ex, input logic er, input logic eb, input logic ed);
    vec_t e;
    e.v = v; e.d = d; e.ex = ex; e.er = er; e.eb = eb; e.ed = ed;
    tbl.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fb;
    logic [23:0] got24, e_b2b;
    logic [11:0] got12, e_st;
    logic [4:0]  got1, e_1;
    logic        rnow, acc, rv;
    logic [7:0]  rd;
    int          hits;

    rst_n = 1'b0; din_valid = 1'b0; din = '0; valid1 = 1'b0; din1 = '0;
    #12;
    chk("rst_x", 32'(x), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_ready", 32'(din_ready), 1);
    chk("rst_ready1", 32'(ready1), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single 8'hA5 frame from a table of per-cycle expectations.
    fb = {3'b101, 8'hA5};
    add(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 10; i >= 0; i--)
      add(1'b0, 8'h00, fb[i], (i == 0) && (G == 0), 1'b1, (i == 0) && (G == 0));
    if (G != 0) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      chk("tbl_x", 32'(s_x), 32'(tbl[i].ex));
      chk("tbl_ready", 32'(s_r), 32'(tbl[i].er));
      chk("tbl_busy", 32'(s_b), 32'(tbl[i].eb));
      chk("tbl_done", 32'(s_d), 32'(tbl[i].ed));
    end

    // Back-to-back: valid held high, FF then 00.
    e_b2b = (G != 0) ? {3'b101, 8'hFF, 1'b0, 3'b101, 8'h00, 1'b0}
                     : {2'b00, 3'b101, 8'hFF, 3'b101, 8'h00};
    got24 = '0;
    step(1'b1, 8'hFF);
    for (int k = 0; k < 2 * FL; k++) begin
      step(k < FL, 8'h00);
      got24 = {got24[22:0], s_x};
    end
    chk("b2b_stream", 32'(got24), 32'(e_b2b));

    // Stall: a pulse while busy is dropped; a held valid is taken at the ready slot.
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    repeat (3) step(1'b0, 8'h00);
    acc = 1'b0;
    for (int k = 0; k < 30 && !acc; k++) begin
      rnow = (mq.size() <= 1);
      step(1'b1, 8'h3C);
      acc = rnow;
    end
    chk("stall_accept", 32'(acc), 1);
    e_st  = (G != 0) ? {3'b101, 8'h3C, 1'b0} : {1'b0, 3'b101, 8'h3C};
    got12 = '0;
    for (int k = 0; k < FL; k++) begin
      step(1'b0, 8'h00);
      got12 = {got12[10:0], s_x};
    end
    chk("stall_stream", 32'(got12), 32'(e_st));
    step(1'b0, 8'h00);

    // Asynchronous reset in the middle of the payload.
    step(1'b1, 8'hFF);
    repeat (5) step(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", 32'(x), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(frame_done), 0);
    chk("midrst_ready", 32'(din_ready), 1);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // DATA_W = 1 instance: frame 1,0,1,1 (plus guard 0).
    e_1 = (G != 0) ? 5'b10110 : 5'b01011;
    got1 = '0;
    valid1 = 1'b1; din1 = 1'b1;
    step(1'b0, 8'h00);
    valid1 = 1'b0;
    hits = 0;
    for (int k = 0; k < 4 + G; k++) begin
      got1 = {got1[3:0], x1};
      chk("w1_ready", 32'(ready1), 32'(k == 3 + G));
      chk("w1_done", 32'(done1), 32'(k == 3 + G));
      step(1'b0, 8'h00);
    end
    chk("w1_stream", 32'(got1), 32'(e_1));
    chk("w1_idle", 32'(x1 | busy1), 0);
    for (int k = 0; k + 2 < 5; k++)
      if (got1[k +: 3] == 3'b101) hits++;
    chk("w1_detect", 32'(hits), 1);

    // Random traffic against the frame-queue model.
    repeat (400) begin
      rv = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      step(rv, rd);
    end
    repeat (FL + 1) step(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_marker_tx.md
# seq_marker_tx

Serial frame transmitter that produces the bitstream the team's Moore "101" sequence detectors consume. Accepts a parallel word over a valid/ready handshake. Emits a 3-bit `1,0,1` sync marker followed by the word, MSB first, on a single serial line, one bit per clock. Sits on the driving side of the serial link, feeding the detector's `x` input directly.

## Interface
- `DATA_W`, default 8: payload bits per frame; legal range 1..32.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `din` input, `DATA_W`: payload word; sampled on accept.
- `din_valid` input, 1: payload word present.
- `din_ready` output, 1: transmitter can accept a word this cycle.
- `x` output, 1: serial bit (Moore output, depends only on registered state).
- `busy` output, 1: high whenever the state is not IDLE.
- `frame_done` output, 1: one-cycle pulse during the last bit slot of a frame.

## Operation
- States: IDLE, MK1, MK0, MK2, DATA, GUARD (GUARD exists only with the guard feature).
- Accept rule: a word is accepted on any rising edge where `din_valid && din_ready`.
  - On accept, `din` is latched into the shift register `sh[DATA_W-1:0]`.
  - The bit counter is set to `DATA_W-1`.
- `x` per state:
  - IDLE = 0, MK1 = 1, MK0 = 0, MK2 = 1.
  - DATA = `sh[DATA_W-1]`.
  - GUARD = 0.
- Transitions:
  - IDLE goes to MK1 on accept; otherwise stays in IDLE.
  - MK1 goes to MK0, and MK0 goes to MK2, unconditionally.
  - MK2 goes to DATA.
  - DATA with count > 0: shift `sh` left by 1, decrement count, stay in DATA.
  - DATA with count == 0: this is the last payload bit.
    - With the guard feature: go to GUARD.
    - Without the guard feature: go to MK1 if a word is accepted this cycle, else to IDLE.
  - GUARD goes to MK1 if a word is accepted this cycle, else to IDLE.
  - Unused encodings go to IDLE with `x` = 0.
- `din_ready` is high when any of these holds:
  - state is IDLE;
  - state is DATA, count == 0, and the guard feature is absent;
  - state is GUARD.
- `frame_done` is high during the last slot of the frame:
  - DATA with count == 0 when there is no guard;
  - GUARD when the guard feature is present.
- `din` and `din_valid` are ignored while `din_ready` is low. A held `din_valid` is not lost; it is accepted at the next ready slot.
- Payload is not scrambled. A payload containing `101` is the detector's concern; the marker only delimits frame start.

## Timing
- Reset (asynchronous, at any time including mid-frame) forces:
  - state to IDLE, `sh` to 0, count to 0;
  - `x` = 0, `busy` = 0, `frame_done` = 0, `din_ready` = 1.
- A partially sent frame is abandoned and `x` returns to 0 with no clock edge needed.
- Latency: accept at edge N puts the first marker bit on `x` in the cycle after edge N. Payload MSB appears after edge N+3.
- Frame length: `3 + DATA_W` cycles, plus 1 with the guard feature.
- Back-to-back: an accept in the last slot starts MK1 on the next cycle with no idle gap. Sustained throughput is one word per frame length.
- `DATA_W` = 1: DATA lasts one cycle, count is 0 on entry, and `din_ready` and `frame_done` assert there.

## Configuration
- `SEQ_MARKER_TX_GUARD_EN` defined:
  - the GUARD state is compiled in;
  - every frame ends with one forced `x` = 0 bit;
  - the guard bit guarantees a non-overlapping "101" detector sees a 0 between payload and the next marker.
- `SEQ_MARKER_TX_GUARD_EN` undefined:
  - the GUARD state is absent;
  - frames are contiguous.

## Test plan
- Reset: assert `rst_n` = 0 mid-DATA.
  - Response: `x`/`busy`/`frame_done` go to 0 immediately and `din_ready` goes to 1.
  - After release, IDLE outputs 0 until the next accept.
- Single frame, `DATA_W` = 8, `din` = 8'hA5, no guard.
  - Response: `x` = 1,0,1,1,0,1,0,0,1,0,1 over 11 cycles, then 0.
  - `frame_done` pulses on the 11th cycle.
- Single frame, 8'hA5, with `SEQ_MARKER_TX_GUARD_EN`.
  - Response: same 11 bits plus a trailing 0.
  - `frame_done` pulses on the 12th cycle.
- Back-to-back: `din_valid` held high with 8'hFF then 8'h00, no guard.
  - Response: 1,0,1, eight 1s, then 1,0,1, eight 0s, with no gap.
  - `din_ready` is high only in IDLE and in the last slot.
- Stall: `din_valid` pulses with 8'h3C while `busy`.
  - Response: the word is not accepted and `x` is unaffected.
  - Holding `din_valid` until the ready slot sends 8'h3C next.
- Edge case `DATA_W` = 1, `din` = 1.
  - Response: frame 1,0,1,1 (4 cycles).
  - Loopback into the team's "101" detector flags exactly one detection per frame.
